per_elastic_slice: RTL and testbench

// - Timing/elastic stage on the peripheral side of the AXI-to-peripheral bridge.
// - Sits between the bridge's peripheral master port and the cluster peripheral interconnect.
// - Buffers requests in a small FIFO and registers responses, cutting all req->gnt
//   and r_valid combinational paths.
// - Limits the number of outstanding transactions and reports activity on busy_o.

---
 rtl/per_elastic_slice.sv | 157 +++++++++++++++
 tb/tb_per_elastic_slice.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/per_elastic_slice.sv
`timescale 1ns/1ps
// Elastic request/response slice: requests buffered in a FIFO (>=1 cycle), responses registered (+1 cycle).
// Upstream grant is purely registered: withheld when the FIFO is full or the outstanding limit is reached.

module per_elastic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic             ovf
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push, pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push     = push_vld && !full;
  assign pop      = pop_rdy && !empty;
  assign ovf      = push_vld && full;
  assign head_dat = mem[rd_ptr];

  // Storage is reset so the head (and thus the downstream payload) reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module per_elastic_slice #(
  parameter int PER_ADDR_WIDTH  = 32,
  parameter int PER_DATA_WIDTH  = 32,
  parameter int PER_BE_WIDTH    = PER_DATA_WIDTH / 8,
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      slv_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] slv_add_i,
  input  logic                      slv_wen_i,
  input  logic [PER_DATA_WIDTH-1:0] slv_wdata_i,
  input  logic [PER_BE_WIDTH-1:0]   slv_be_i,
  output logic                      slv_gnt_o,
  output logic                      slv_r_valid_o,
  output logic                      slv_r_opc_o,
  output logic [PER_DATA_WIDTH-1:0] slv_r_rdata_o,
  output logic                      mst_req_o,
  output logic [PER_ADDR_WIDTH-1:0] mst_add_o,
  output logic                      mst_wen_o,
  output logic [PER_DATA_WIDTH-1:0] mst_wdata_o,
  output logic [PER_BE_WIDTH-1:0]   mst_be_o,
  input  logic                      mst_gnt_i,
  input  logic                      mst_r_valid_i,
  input  logic                      mst_r_opc_i,
  input  logic [PER_DATA_WIDTH-1:0] mst_r_rdata_i,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [PER_ADDR_WIDTH-1:0] add;
    logic                      wen;
    logic [PER_DATA_WIDTH-1:0] wdata;
    logic [PER_BE_WIDTH-1:0]   be;
  } req_t;

  req_t             push_dat, head_dat;
  logic             fifo_full, fifo_empty, fifo_ovf;
  logic             slv_hs, unexp_rsp, ready_q;
  logic [CNT_W-1:0] out_cnt;

  assign push_dat = '{add: slv_add_i, wen: slv_wen_i, wdata: slv_wdata_i, be: slv_be_i};

  // ready_q keeps the grant low while reset is asserted and for the first cycle after it.
  assign slv_gnt_o = ready_q && !fifo_full && (out_cnt < CNT_W'(MAX_OUTSTANDING));
  assign slv_hs    = slv_req_i && slv_gnt_o;

  per_elastic_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (slv_hs),
    .push_dat (push_dat),
    .pop_rdy  (mst_gnt_i),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (fifo_ovf)
  );

  assign mst_req_o   = !fifo_empty;
  assign mst_add_o   = head_dat.add;
  assign mst_wen_o   = head_dat.wen;
  assign mst_wdata_o = head_dat.wdata;
  assign mst_be_o    = head_dat.be;

  // A response is unexpected if no granted request remains unanswered after this cycle's retirement.
  assign unexp_rsp = mst_r_valid_i && (out_cnt == CNT_W'(slv_r_valid_o));
  assign busy_o    = (out_cnt != '0) || slv_r_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q       <= 1'b0;
      slv_r_valid_o <= 1'b0;
      slv_r_opc_o   <= 1'b0;
      slv_r_rdata_o <= '0;
      out_cnt       <= '0;
      err_o         <= 1'b0;
    end else begin
      ready_q       <= 1'b1;
      slv_r_valid_o <= mst_r_valid_i;
      if (mst_r_valid_i) begin
        slv_r_opc_o   <= mst_r_opc_i;
        slv_r_rdata_o <= mst_r_rdata_i;
      end
      case ({slv_hs, slv_r_valid_o})
        2'b10:   if (out_cnt != CNT_W'(MAX_OUTSTANDING)) out_cnt <= out_cnt + 1'b1;
        2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (unexp_rsp || fifo_ovf) err_o <= 1'b1;
    end
  end

  a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni) !fifo_ovf);
  a_unexp_flags: assert property (@(posedge clk_i) disable iff (!rst_ni) unexp_rsp |=> err_o);
endmodule

// File: tb/tb_per_elastic_slice.sv
`timescale 1ns/1ps
// Directed bench for per_elastic_slice with default parameters (FIFO_DEPTH=2, MAX_OUTSTANDING=4).
module tb_per_elastic_slice;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, wen = 1'b0;
  logic [31:0] add = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rv, opc, mreq, mwen, busy, err;
  logic [31:0] rdata, madd, mwdata;
  logic [3:0]  mbe;
  logic        mgnt = 1'b0, mrv = 1'b0, mopc = 1'b0;
  logic [31:0] mrdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  per_elastic_slice dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(req), .slv_add_i(add), .slv_wen_i(wen), .slv_wdata_i(wdata), .slv_be_i(be),
    .slv_gnt_o(gnt), .slv_r_valid_o(rv), .slv_r_opc_o(opc), .slv_r_rdata_o(rdata),
    .mst_req_o(mreq), .mst_add_o(madd), .mst_wen_o(mwen), .mst_wdata_o(mwdata), .mst_be_o(mbe),
    .mst_gnt_i(mgnt), .mst_r_valid_i(mrv), .mst_r_opc_i(mopc), .mst_r_rdata_i(mrdata),
    .busy_o(busy), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_mreq", mreq, 0);
    chk("rst_madd", madd, 0);
    chk("rst_mwdata", mwdata, 0);
    chk("rst_rv", rv, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", gnt, 1);

    // Single write
    req = 1; add = 32'h1000_0004; wen = 0; wdata = 32'hDEAD_BEEF; be = 4'hF; mgnt = 1;
    tick();
    req = 0;
    chk("wr_mreq", mreq, 1);
    chk("wr_madd", madd, 32'h1000_0004);
    chk("wr_mwdata", mwdata, 32'hDEAD_BEEF);
    chk("wr_mwen", mwen, 0);
    chk("wr_mbe", mbe, 4'hF);
    chk("wr_busy_a", busy, 1);
    tick();
    chk("wr_mreq_pop", mreq, 0);
    chk("wr_busy_b", busy, 1);
    mrv = 1; mopc = 0; mrdata = 32'h0;
    tick();
    mrv = 0;
    chk("wr_rv", rv, 1);
    chk("wr_busy_c", busy, 1);
    tick();
    chk("wr_rv_done", rv, 0);
    chk("wr_busy_done", busy, 0);

    // Downstream stall with three reads
    mgnt = 0; req = 1; wen = 1; add = 32'h100;
    tick();
    chk("st_gnt1", gnt, 1);
    add = 32'h104;
    tick();
    add = 32'h108;
    chk("st_gnt_full", gnt, 0);
    chk("st_mreq", mreq, 1);
    chk("st_madd0", madd, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_gnt", gnt, 0);
      chk("st_hold_madd", madd, 32'h100);
    end
    mgnt = 1;
    tick();
    chk("st_madd1", madd, 32'h104);
    chk("st_gnt_next", gnt, 1);
    tick();
    req = 0;
    chk("st_madd2", madd, 32'h108);
    chk("st_mwen", mwen, 1);
    tick();
    chk("st_drained", mreq, 0);
    mrv = 1; mopc = 0; mrdata = 32'hA0;
    tick();
    mrdata = 32'hA1;
    chk("st_rd0", rdata, 32'hA0);
    chk("st_rv0", rv, 1);
    tick();
    mrdata = 32'hA2;
    chk("st_rd1", rdata, 32'hA1);
    tick();
    mrv = 0; mrdata = 32'hFFFF_FFFF;
    chk("st_rd2", rdata, 32'hA2);
    tick();
    chk("st_rd_hold", rdata, 32'hA2);
    chk("st_busy_done", busy, 0);
    chk("st_err", err, 0);

    // Outstanding limit with responses withheld
    req = 1; wen = 0; add = 32'h200;
    for (int i = 0; i < 4; i++) begin
      chk("ol_gnt", gnt, 1);
      tick();
    end
    chk("ol_gnt_limit", gnt, 0);
    tick();
    chk("ol_gnt_limit2", gnt, 0);
    mrv = 1; mrdata = 32'h0;
    tick();
    mrv = 0;
    chk("ol_gnt_rsp", gnt, 0);
    tick();
    chk("ol_gnt_one", gnt, 1);
    tick();
    chk("ol_gnt_again0", gnt, 0);
    req = 0;
    mrv = 1;
    for (int i = 0; i < 4; i++) tick();
    mrv = 0;
    tick();
    chk("ol_busy_done", busy, 0);
    chk("ol_err", err, 0);

    // Response retired and request granted in the same cycle
    req = 1; add = 32'h300;
    tick();
    req = 0;
    tick();
    mrv = 1;
    tick();
    mrv = 0; req = 1; add = 32'h304;
    chk("sim_rv", rv, 1);
    tick();
    req = 0;
    chk("sim_busy", busy, 1);
    chk("sim_mreq", mreq, 1);
    mrv = 1;
    tick();
    mrv = 0;
    chk("sim_err", err, 0);
    chk("sim_busy2", busy, 1);
    tick();
    chk("sim_busy_done", busy, 0);

    // Unexpected response
    chk("ux_err_pre", err, 0);
    mrv = 1; mopc = 1; mrdata = 32'h55;
    tick();
    mrv = 0; mopc = 0;
    chk("ux_err", err, 1);
    chk("ux_rv", rv, 1);
    chk("ux_opc", opc, 1);
    chk("ux_rdata", rdata, 32'h55);
    tick();
    chk("ux_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ux_sticky", err, 1);
    end

    // Reset mid-burst with two buffered requests
    mgnt = 0; req = 1; add = 32'h400;
    tick();
    add = 32'h404;
    tick();
    req = 0;
    chk("rb_mreq", mreq, 1);
    chk("rb_busy", busy, 1);
    chk("rb_madd", madd, 32'h400);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_async_mreq", mreq, 0);
    chk("rb_async_busy", busy, 0);
    chk("rb_async_gnt", gnt, 0);
    chk("rb_async_madd", madd, 0);
    chk("rb_async_err", err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rb_gnt", gnt, 1);
    mgnt = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rb_no_stale", mreq, 0);
    end
    chk("rb_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
